alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Holds the 32x32 integer register file and reads rs1/rs2 for an incoming decoded instruction.
- Selects the second operand (rs2 or immediate) and registers Data1/Data2/ALU_Op into a one-entry output slot with valid/ready handshake.
- The ALU consumes the slot's outputs directly. The writeback path writes the register file through a dedicated port.

Parameters:
- XLEN, 32, datapath width of registers, immediate and operands.
- NREGS, 32, number of architectural registers; register address width is log2(NREGS) = 5.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- In_Valid  input  1  decoded instruction present.
- In_Ready  output  1  stage can accept this cycle.
- Rs1  input  5  source register 1 address.
- Rs2  input  5  source register 2 address.
- Rd  input  5  destination register address, passed through.
- Imm  input  XLEN  sign-extended immediate.
- Use_Imm  input  1  1 selects Imm as Data2; 0 selects reg[Rs2].
- ALU_Op_In  input  4  ALU operation code, passed through unchanged.
- Flush  input  1  discard slot contents and any same-cycle accept.
- Out_Valid  output  1  Data1/Data2/ALU_Op/Rd_Out are valid.
- Out_Ready  input  1  consumer takes the slot this cycle.
- Data1  output  XLEN  ALU operand 1.
- Data2  output  XLEN  ALU operand 2.
- ALU_Op  output  4  ALU operation code.
- Rd_Out  output  5  destination register address.
- WB_En  input  1  register-file write enable.
- WB_Addr  input  5  write address.
- WB_Data  input  XLEN  write data.

Behaviour:
- Reset (asynchronous assertion, synchronous-safe deassertion):
  - All registers read 0.
  - Out_Valid=0; Data1, Data2, ALU_Op and Rd_Out are all 0.
- Register file:
  - Write occurs on the rising edge when WB_En=1 and WB_Addr!=0.
  - Writes to x0 are ignored; reads of x0 always return 0.
  - Reads are combinational from the current array contents.
- Slot state machine:
  - EMPTY (Out_Valid=0) and FULL (Out_Valid=1).
  - In_Ready = !Out_Valid || Out_Ready, combinational, and independent of In_Valid.
- Accept (In_Valid && In_Ready && !Flush):
  - Next edge loads Data1=reg[Rs1].
  - Data2 = Use_Imm ? Imm : reg[Rs2].
  - ALU_Op=ALU_Op_In, Rd_Out=Rd.
  - State becomes FULL.
- Other transitions:
  - FULL && Out_Ready && no accept -> EMPTY.
  - FULL && Out_Ready && accept -> FULL with the new contents (back-to-back, one instruction per cycle).
  - FULL && !Out_Ready: hold all outputs stable; In_Ready=0.
- Latency: 1 cycle from accept to Out_Valid.
- Flush:
  - Next edge forces EMPTY regardless of In_Valid or Out_Ready.
  - Data outputs may keep stale values; consumers must qualify with Out_Valid.
  - Register-file writes in the same cycle still take effect.
- Operands are sampled at accept. A held slot is NOT refreshed by later writebacks.
- Same-cycle write and read of the same register without the optional feature: the captured operand is the old value.
- Reset asserted mid-operation: the slot empties and the register file clears immediately.

Optional Feature:
- Macro: ALU_OPERAND_STAGE_WB_BYPASS_EN
- Defined: when WB_En=1, WB_Addr!=0 and WB_Addr equals Rs1 (or Rs2 with Use_Imm=0) in an accept cycle, the captured operand is WB_Data. Write-then-read semantics.
- Undefined: no bypass; the old register value is captured.

Decomposition:
- Shared package:
  - XLEN and register-address width constants.
  - ALU opcode localparams: SLL=0000, SRL=0010, ADD=1000, SUB=1010, AND=1100, OR=1101.
  - Register index constant REG_ZERO=0.
- One natural sub-module: reg_file. It has two combinational read ports, one synchronous write port and the x0 rule; the bypass logic is optional inside it.

Test Plan:
- Reset then read: assert Reset mid-stream with a FULL slot -> Out_Valid=0 at once; accepting Rs1=5, Rs2=7 afterwards gives Data1=0, Data2=0.
- Write/read: WB x3=0x0000_00AA, then accept Rs1=3, Rs2=0, Use_Imm=0, ALU_Op_In=1000 -> next cycle Out_Valid=1, Data1=0xAA, Data2=0, ALU_Op=1000.
- x0 protection: WB_En=1, WB_Addr=0, WB_Data=0xFFFF_FFFF, then accept Rs1=0 -> Data1=0.
- Immediate select: x4=0x10, accept Rs1=4, Use_Imm=1, Imm=0xFFFF_FFFC -> Data1=0x10, Data2=0xFFFF_FFFC.
- Backpressure and flush:
  - Out_Ready=0 for 3 cycles with FULL -> outputs stable and In_Ready=0.
  - Then Out_Ready=1 with In_Valid=1 -> new contents in one cycle.
  - Then Flush=1 with In_Valid=1 -> Out_Valid=0 next cycle.
- Same-cycle hazard: x9=1; in one cycle WB x9=2 and accept Rs1=9 -> Data1=1 without the macro, Data1=2 with ALU_OPERAND_STAGE_WB_BYPASS_EN.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared constants, ALU opcodes and slot state type for the ALU operand stage.
package alu_operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] SLL = 4'b0000;
    localparam logic [OP_W-1:0] SRL = 4'b0010;
    localparam logic [OP_W-1:0] ADD = 4'b1000;
    localparam logic [OP_W-1:0] SUB = 4'b1010;
    localparam logic [OP_W-1:0] AND = 4'b1100;
    localparam logic [OP_W-1:0] OR  = 4'b1101;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // True when a writeback this cycle lands on a real (non-x0) register at rd_addr.
    function automatic logic wb_hits(
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_addr,
        input logic [REG_AW-1:0] rd_addr
    );
        return wb_en && (wb_addr != REG_ZERO) && (wb_addr == rd_addr);
    endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// 32-entry register file: two combinational read ports, one write port, x0 hardwired to zero.
// Writeback-to-read bypass is enabled by defining ALU_OPERAND_STAGE_WB_BYPASS_EN.
module alu_operand_stage_reg_file
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data
);

    logic [XLEN-1:0] regs_r [NREGS];

    // Register array: cleared on reset, written on writeback except to x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_hits(wb_en, wb_addr, wb_addr)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Read port 1, with optional write-then-read forwarding.
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        if (rs1_addr == REG_ZERO) begin
            rs1_data = {XLEN{1'b0}};
        end else begin
            rs1_data = regs_r[rs1_addr];
        end
`ifdef ALU_OPERAND_STAGE_WB_BYPASS_EN
        if (wb_hits(wb_en, wb_addr, rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = rs1_data;
        end
`endif
    end

    // Read port 2, with optional write-then-read forwarding.
    always_comb begin
        rs2_data = {XLEN{1'b0}};
        if (rs2_addr == REG_ZERO) begin
            rs2_data = {XLEN{1'b0}};
        end else begin
            rs2_data = regs_r[rs2_addr];
        end
`ifdef ALU_OPERAND_STAGE_WB_BYPASS_EN
        if (wb_hits(wb_en, wb_addr, rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = rs2_data;
        end
`endif
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: register-file read, operand-2 select, one-entry output slot.
// Optional writeback bypass: define ALU_OPERAND_STAGE_WB_BYPASS_EN.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [REG_AW-1:0] Rs1,
    input  logic [REG_AW-1:0] Rs2,
    input  logic [REG_AW-1:0] Rd,
    input  logic [XLEN-1:0]   Imm,
    input  logic              Use_Imm,
    input  logic [OP_W-1:0]   ALU_Op_In,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [XLEN-1:0]   Data1,
    output logic [XLEN-1:0]   Data2,
    output logic [OP_W-1:0]   ALU_Op,
    output logic [REG_AW-1:0] Rd_Out,
    input  logic              WB_En,
    input  logic [REG_AW-1:0] WB_Addr,
    input  logic [XLEN-1:0]   WB_Data
);

    slot_state_e     state_r;
    slot_state_e     state_next_s;
    logic            accept_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;
    logic [XLEN-1:0] operand2_s;

    alu_operand_stage_reg_file u_reg_file (
        .clk      (Clk),
        .rst      (Reset),
        .rs1_addr (Rs1),
        .rs2_addr (Rs2),
        .rs1_data (rs1_data_s),
        .rs2_data (rs2_data_s),
        .wb_en    (WB_En),
        .wb_addr  (WB_Addr),
        .wb_data  (WB_Data)
    );

    assign Out_Valid = (state_r == SLOT_FULL);
    assign In_Ready  = !Out_Valid || Out_Ready;
    assign accept_s  = In_Valid && In_Ready && !Flush;

    // Slot state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next slot state; flush wins over both accept and drain.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (accept_s) begin
                    state_next_s = SLOT_FULL;
                end else begin
                    state_next_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (Flush) begin
                    state_next_s = SLOT_EMPTY;
                end else if (accept_s) begin
                    state_next_s = SLOT_FULL;
                end else if (Out_Ready) begin
                    state_next_s = SLOT_EMPTY;
                end else begin
                    state_next_s = SLOT_FULL;
                end
            end
            default: state_next_s = SLOT_EMPTY;
        endcase
    end

    // Second operand select.
    always_comb begin
        operand2_s = {XLEN{1'b0}};
        if (Use_Imm) begin
            operand2_s = Imm;
        end else begin
            operand2_s = rs2_data_s;
        end
    end

    // Slot payload: captured only on accept, so held or flushed contents stay put.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Data1  <= {XLEN{1'b0}};
            Data2  <= {XLEN{1'b0}};
            ALU_Op <= {OP_W{1'b0}};
            Rd_Out <= {REG_AW{1'b0}};
        end else if (accept_s) begin
            Data1  <= rs1_data_s;
            Data2  <= operand2_s;
            ALU_Op <= ALU_Op_In;
            Rd_Out <= Rd;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: driver pushes expected slot contents, monitor pops on handshake.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [4:0]  Rs1, Rs2, Rd;
    logic [31:0] Imm;
    logic        Use_Imm;
    logic [3:0]  ALU_Op_In;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Data1, Data2;
    logic [3:0]  ALU_Op;
    logic [4:0]  Rd_Out;
    logic        WB_En;
    logic [4:0]  WB_Addr;
    logic [31:0] WB_Data;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_operand_stage dut (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Imm(Imm), .Use_Imm(Use_Imm),
        .ALU_Op_In(ALU_Op_In), .Flush(Flush), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Data1(Data1), .Data2(Data2), .ALU_Op(ALU_Op),
        .Rd_Out(Rd_Out), .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t mk(input logic [31:0] d1, input logic [31:0] d2,
                                input logic [3:0] op, input logic [4:0] rd);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.op = op; e.rd = rd;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake must match the oldest outstanding expectation.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Reset && Out_Valid && Out_Ready && !Flush) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output d1=%0h d2=%0h op=%0h rd=%0d",
                         Data1, Data2, ALU_Op, Rd_Out);
            end else begin
                e = sb_q.pop_front();
                if ({Data1, Data2, ALU_Op, Rd_Out} !== e) begin
                    failures++;
                    $display("FAIL slot_out actual d1=%0h d2=%0h op=%0h rd=%0d required d1=%0h d2=%0h op=%0h rd=%0d",
                             Data1, Data2, ALU_Op, Rd_Out, e.d1, e.d2, e.op, e.rd);
                end
            end
        end
    end

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        WB_En = 1'b1; WB_Addr = a; WB_Data = d;
        @(posedge Clk); #1;
        WB_En = 1'b0;
    endtask

    task automatic present(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic ui, input logic [3:0] op);
        In_Valid = 1'b1; Rs1 = r1; Rs2 = r2; Rd = rd; Imm = imm; Use_Imm = ui; ALU_Op_In = op;
    endtask

    task automatic wait_accept(input exp_t e);
        int n = 0;
        @(negedge Clk);
        while (!In_Ready && n < 20) begin
            n++;
            @(negedge Clk);
        end
        if (!In_Ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=In_Ready_low required=accept_within_20");
        end else begin
            sb_q.push_back(e);
        end
        @(posedge Clk); #1;
        In_Valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; In_Valid = 1'b0; Rs1 = 5'd0; Rs2 = 5'd0; Rd = 5'd0; Imm = 32'd0;
        Use_Imm = 1'b0; ALU_Op_In = 4'd0; Flush = 1'b0; Out_Ready = 1'b1;
        WB_En = 1'b0; WB_Addr = 5'd0; WB_Data = 32'd0;
        #12;
        check("reset_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("reset_data1", {32'd0, Data1}, 64'd0);
        check("reset_data2", {32'd0, Data2}, 64'd0);
        check("reset_alu_op", {60'd0, ALU_Op}, 64'd0);
        check("reset_rd_out", {59'd0, Rd_Out}, 64'd0);
        check("reset_in_ready", {63'd0, In_Ready}, 64'd1);
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk); #1;

        // Write then read
        wb(5'd3, 32'h0000_00AA);
        present(5'd3, 5'd0, 5'd1, 32'd0, 1'b0, ADD);
        wait_accept(mk(32'h0000_00AA, 32'd0, ADD, 5'd1));
        // x0 protection
        wb(5'd0, 32'hFFFF_FFFF);
        present(5'd0, 5'd0, 5'd2, 32'd0, 1'b0, SUB);
        wait_accept(mk(32'd0, 32'd0, SUB, 5'd2));
        // Immediate select, rs2 points at a nonzero register
        wb(5'd4, 32'h0000_0010);
        present(5'd4, 5'd3, 5'd4, 32'hFFFF_FFFC, 1'b1, OR);
        wait_accept(mk(32'h0000_0010, 32'hFFFF_FFFC, OR, 5'd4));
        // Back-to-back register operand 2
        present(5'd3, 5'd4, 5'd5, 32'h0000_0055, 1'b0, AND);
        wait_accept(mk(32'h0000_00AA, 32'h0000_0010, AND, 5'd5));

        // Backpressure: hold A for 3 cycles while a writeback changes its source register
        wb(5'd6, 32'h0000_0066);
        Out_Ready = 1'b0;
        present(5'd6, 5'd0, 5'd6, 32'd0, 1'b0, SLL);
        wait_accept(mk(32'h0000_0066, 32'd0, SLL, 5'd6));
        present(5'd3, 5'd6, 5'd7, 32'd0, 1'b0, SRL);
        WB_En = 1'b1; WB_Addr = 5'd6; WB_Data = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("stall_in_ready", {63'd0, In_Ready}, 64'd0);
            check("stall_out_valid", {63'd0, Out_Valid}, 64'd1);
            check("stall_data1", {32'd0, Data1}, 64'h66);
            check("stall_rd_out", {59'd0, Rd_Out}, 64'd6);
            @(posedge Clk); #1;
            WB_En = 1'b0;
        end
        Out_Ready = 1'b1;
        wait_accept(mk(32'h0000_00AA, 32'h0000_0077, SRL, 5'd7));

        // Flush of a full slot with a pending instruction
        Out_Ready = 1'b0; Flush = 1'b1;
        present(5'd3, 5'd3, 5'd8, 32'd0, 1'b0, ADD);
        @(posedge Clk); #1;
        Flush = 1'b0; In_Valid = 1'b0;
        void'(sb_q.pop_back());
        @(negedge Clk);
        check("flush_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("flush_in_ready", {63'd0, In_Ready}, 64'd1);
        Out_Ready = 1'b1;
        @(posedge Clk); #1;

        // Same-cycle writeback and read of x9
        wb(5'd9, 32'd1);
        WB_En = 1'b1; WB_Addr = 5'd9; WB_Data = 32'd2;
        present(5'd9, 5'd0, 5'd9, 32'd0, 1'b0, ADD);
`ifdef ALU_OPERAND_STAGE_WB_BYPASS_EN
        wait_accept(mk(32'd2, 32'd0, ADD, 5'd9));
`else
        wait_accept(mk(32'd1, 32'd0, ADD, 5'd9));
`endif
        WB_En = 1'b0;
        present(5'd0, 5'd9, 5'd12, 32'd0, 1'b0, SUB);
        wait_accept(mk(32'd0, 32'd2, SUB, 5'd12));

        // Reset mid-stream with a full slot
        wb(5'd5, 32'h0000_0055);
        wb(5'd7, 32'h0000_0077);
        Out_Ready = 1'b0;
        present(5'd5, 5'd7, 5'd10, 32'd0, 1'b0, SUB);
        wait_accept(mk(32'h0000_0055, 32'h0000_0077, SUB, 5'd10));
        #1;
        check("pre_reset_out_valid", {63'd0, Out_Valid}, 64'd1);
        Reset = 1'b1;
        #1;
        check("midreset_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("midreset_data1", {32'd0, Data1}, 64'd0);
        void'(sb_q.pop_back());
        @(negedge Clk); Reset = 1'b0; Out_Ready = 1'b1;
        @(posedge Clk); #1;
        present(5'd5, 5'd7, 5'd11, 32'd0, 1'b0, ADD);
        wait_accept(mk(32'd0, 32'd0, ADD, 5'd11));

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
